axi_rd_responder: RTL
=====================

# axi_rd_responder

AXI4 read-only subordinate that serves read bursts out of a simple single-port memory (req/gnt/rvalid). It is the memory-side counterpart of the L1I$ AXI refill path: it answers icache line refills (multi-beat INCR) and bypassed single-word fetches. It is used in the core testharness and as a boot-ROM/scratchpad front end. Responses are returned in order, one burst issued at a time. A small response FIFO absorbs R-channel backpressure.

## Interface
- AxiAddrWidth, 64: AXI and memory byte-address width.
- AxiDataWidth, 64: AXI R data width and memory word width.
- AxiIdWidth, 4: AR/R ID width.
- axi_req_t, ariane_axi::req_t: AXI request struct type.
- axi_rsp_t, ariane_axi::resp_t: AXI response struct type.
- FifoDepth, 4: response FIFO entries; also the maximum number of outstanding memory reads. Must be ≥2 and a power of two.
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- axi_req_i  in  axi_req_t  AXI request; only the AR channel and r_ready are used.
- axi_resp_o  out  axi_rsp_t  AXI response; the AR and R channels are driven. aw_ready, w_ready and b_valid are tied to 0 (the block is read-only).
- mem_req_o  out  1  memory read request.
- mem_gnt_i  in  1  memory grant.
- mem_addr_o  out  AxiAddrWidth  byte address, aligned to the beat size.
- mem_rvalid_i  in  1  read data valid. Arrives exactly 1 cycle after grant, in order.
- mem_rdata_i  in  AxiDataWidth  read data.

## Operation
- FSM states: IDLE and BURST.
  - IDLE: ar_ready=1. An AR handshake latches id, addr, len, size and burst, loads beat counter := len, and moves to BURST.
  - BURST: ar_ready=0. mem_req_o=1 while credit is available. On each grant: addr := next address, counter decrements. The grant of the final beat (counter==0) returns to IDLE. A new AR is accepted while earlier beats are still draining through the FIFO.
- Credit: an outstanding counter, width $clog2(FifoDepth)+1.
  - +1 on mem grant, −1 on R handshake; both in the same cycle means no change.
  - mem_req_o requires outstanding < FifoDepth.
- Address generation (size s, beat bytes 2^s):
  - FIXED: address is constant.
  - INCR: the first beat uses the address as given; later beats use (addr aligned down to 2^s) + 2^s. Arithmetic is modulo 2^AxiAddrWidth.
  - WRAP: see Configuration.
- Every memory request carries addr with the low s bits cleared.
- FIFO entry = {data, id, last, resp}. The entry is pushed on mem_rvalid_i, with last = (beat was the final grant).
- The R channel presents the FIFO head. r_valid = FIFO not empty. Pop on r_valid & r_ready.
- Error bursts are answered with r_resp=SLVERR and r_data=0 for all len+1 beats, with no memory access. The beats are pushed directly, one per cycle, subject to credit. An error burst is one of:
  - size > $clog2(AxiDataWidth/8);
  - burst type 2'b11;
  - an unsupported WRAP.
- Otherwise r_resp=OKAY.
- Reset values: state IDLE, ar_ready=1, r_valid=0, r_last=0, mem_req_o=0, FIFO empty, outstanding 0.
- Reset mid-burst: all state is discarded immediately. No partial beats are emitted after release.

## Timing
- AR handshake in cycle N. mem_req_o is first asserted in N+1 (registered FSM).
- Grant in cycle G → mem_rvalid_i in G+1 → FIFO write in G+1 → r_valid in G+2 (registered FIFO output). The earliest first R beat is N+3.
- With r_ready held high and mem_gnt_i always 1, throughput is one beat per cycle.
- mem_req_o and mem_addr_o hold stable until granted.
- r_valid holds, with payload stable, until r_ready.
- FIFO full together with r_ready high: pop and push occur in the same cycle without loss.
- mem_rvalid_i while the FIFO is full cannot occur, because credit prevents it.

## Configuration
- AXI_RD_RESP_WRAP_EN defined:
  - WRAP bursts with len ∈ {1,3,7,15} and an aligned start are supported.
  - The wrap boundary is (len+1)·2^s, and the address wraps within the aligned window.
  - Other WRAP forms give SLVERR.
- AXI_RD_RESP_WRAP_EN undefined: every WRAP burst gives SLVERR for all beats, with no memory access.

## Structure
- The ariane_axi package holds axi_req_t/axi_rsp_t.
- Add to ariane_axi:
  - resp encodings OKAY=2'b00, SLVERR=2'b10;
  - burst encodings FIXED/INCR/WRAP.
- One sub-module: axi_rd_responder_fifo, a parameterized synchronous FIFO (registered head, full/empty, same-cycle push/pop).

## Test plan
- Icache refill: AR addr=0x8000_0040, len=3, size=3, INCR, id=0, r_ready=1, gnt=1 → mem addresses 0x40, 0x48, 0x50, 0x58. Four R beats at N+3..N+6, r_last on the 4th, id 0, OKAY.
- Bypassed fetch: AR addr=0x8000_0004, len=0, size=2 → one mem request at 0x8000_0004. One beat with r_last=1. ar_ready is back high at N+2.
- Backpressure: 8-beat INCR with r_ready=0 for 10 cycles → exactly FifoDepth=4 grants, then mem_req_o low. With r_ready=1, all 8 beats arrive in order.
- Memory stall: mem_gnt_i low for 3 cycles on beat 2 → mem_addr_o stable throughout. R data order is preserved.
- WRAP: addr=0x38, len=3, size=3.
  - With the macro: addresses 0x38, 0x20, 0x28, 0x30.
  - Without the macro: 4 SLVERR beats, no mem_req_o.
- Size 4 on 64-bit data → SLVERR beats with len+1 count. Then rst_ni pulsed during a 16-beat burst → r_valid=0, ar_ready=1 after release.

Source files
------------

// File: rtl/ariane_axi.sv
// Slice of the ariane_axi package used by the read responder:
// AXI4 request/response structs and the resp/burst encodings.
package ariane_axi;

   localparam int unsigned AddrWidth = 64;
   localparam int unsigned DataWidth = 64;
   localparam int unsigned IdWidth   = 4;

   localparam logic [1:0] RespOkay   = 2'b00;
   localparam logic [1:0] RespSlvErr = 2'b10;

   localparam logic [1:0] BurstFixed = 2'b00;
   localparam logic [1:0] BurstIncr  = 2'b01;
   localparam logic [1:0] BurstWrap  = 2'b10;

   typedef struct packed {
      logic [IdWidth-1:0]   id;
      logic [AddrWidth-1:0] addr;
      logic [7:0]           len;
      logic [2:0]           size;
      logic [1:0]           burst;
   } ar_chan_t;

   typedef struct packed {
      logic [IdWidth-1:0]   id;
      logic [DataWidth-1:0] data;
      logic [1:0]           resp;
      logic                 last;
   } r_chan_t;

   typedef struct packed {
      logic     aw_valid;
      logic     w_valid;
      logic     b_ready;
      ar_chan_t ar;
      logic     ar_valid;
      logic     r_ready;
   } req_t;

   typedef struct packed {
      logic    aw_ready;
      logic    w_ready;
      logic    b_valid;
      logic    ar_ready;
      r_chan_t r;
      logic    r_valid;
   } resp_t;

endpackage

// File: rtl/axi_rd_responder_pkg.sv
// FSM state type and burst-legality helper for axi_rd_responder.
package axi_rd_responder_pkg;

   typedef enum logic {StIdle, StBurst} state_e;

   // AXI4 WRAP bursts are only legal with 2, 4, 8 or 16 beats.
   function automatic logic wrap_len_ok(input logic [7:0] len);
      return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
   endfunction

endpackage

// File: rtl/axi_rd_responder_fifo.sv
// Synchronous FIFO with register-array head, full/empty flags and same-cycle push/pop.
module axi_rd_responder_fifo #(
   parameter int unsigned Width = 8,
   parameter int unsigned Depth = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             i_push,
   input  logic [Width-1:0] i_data,
   input  logic             i_pop,
   output logic [Width-1:0] o_data,
   output logic             o_full,
   output logic             o_empty
);
   localparam int unsigned PtrW = $clog2(Depth);
   localparam int unsigned CntW = PtrW + 1;

   logic [Width-1:0] r_mem [Depth];
   logic [PtrW-1:0]  r_wptr, r_rptr;
   logic [CntW-1:0]  r_cnt;
   logic             w_wr, w_rd;

   assign o_full  = (r_cnt == CntW'(Depth));
   assign o_empty = (r_cnt == '0);
   assign w_rd    = i_pop & ~o_empty;
   // A pop in the same cycle frees the slot a push into a full FIFO lands in.
   assign w_wr    = i_push & (~o_full | w_rd);
   assign o_data  = r_mem[r_rptr];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
      end else begin
         if (w_wr) r_wptr <= r_wptr + PtrW'(1);
         if (w_rd) r_rptr <= r_rptr + PtrW'(1);
         r_cnt <= r_cnt + CntW'(w_wr) - CntW'(w_rd);
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_wr) r_mem[r_wptr] <= i_data;
   end

endmodule

// File: rtl/axi_rd_responder.sv
// AXI4 read-only subordinate serving bursts from a req/gnt/rvalid memory.
// Optional WRAP support: define AXI_RD_RESP_WRAP_EN.
module axi_rd_responder
   import ariane_axi::*;
   import axi_rd_responder_pkg::*;
#(
   parameter int unsigned AxiAddrWidth = ariane_axi::AddrWidth,
   parameter int unsigned AxiDataWidth = ariane_axi::DataWidth,
   parameter int unsigned AxiIdWidth   = ariane_axi::IdWidth,
   parameter type         axi_req_t    = ariane_axi::req_t,
   parameter type         axi_rsp_t    = ariane_axi::resp_t,
   parameter int unsigned FifoDepth    = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  axi_req_t                axi_req_i,
   output axi_rsp_t                axi_resp_o,
   output logic                    mem_req_o,
   input  logic                    mem_gnt_i,
   output logic [AxiAddrWidth-1:0] mem_addr_o,
   input  logic                    mem_rvalid_i,
   input  logic [AxiDataWidth-1:0] mem_rdata_i
);
   localparam int unsigned     MaxSize = $clog2(AxiDataWidth / 8);
   localparam int unsigned     CntW    = $clog2(FifoDepth) + 1;
   localparam int unsigned     EntW    = AxiDataWidth + AxiIdWidth + 3;
   localparam logic [CntW-1:0] Credits = CntW'(FifoDepth);

   state_e                  r_state, w_state_d;
   logic [AxiIdWidth-1:0]   r_id;
   logic [AxiAddrWidth-1:0] r_addr;
   logic [7:0]              r_len, r_cnt;
   logic [2:0]              r_size;
   logic [1:0]              r_burst;
   logic                    r_err, r_pend_vld, r_pend_last;
   logic [CntW-1:0]         r_outst, w_outst_d;

   logic                    w_ar_hs, w_ar_err, w_wrap_bad;
   logic                    w_issue, w_gnt, w_err_beat, w_beat, w_pop, w_push;
   logic                    w_full, w_empty;
   logic [AxiAddrWidth-1:0] w_bytes, w_align, w_incr, w_wmask, w_next_addr;
   logic [EntW-1:0]         w_push_data, w_head;
   logic                    w_unused;

   assign w_unused = ^{axi_req_i.aw_valid, axi_req_i.w_valid, axi_req_i.b_ready, w_full};

   assign w_ar_hs = axi_req_i.ar_valid & (r_state == StIdle);

`ifdef AXI_RD_RESP_WRAP_EN
   logic [AxiAddrWidth-1:0] w_ar_mask;
   assign w_ar_mask  = (AxiAddrWidth'(1) << axi_req_i.ar.size) - AxiAddrWidth'(1);
   assign w_wrap_bad = (axi_req_i.ar.burst == BurstWrap) &
                       (!wrap_len_ok(axi_req_i.ar.len) || ((axi_req_i.ar.addr & w_ar_mask) != '0));
`else
   assign w_wrap_bad = (axi_req_i.ar.burst == BurstWrap);
`endif

   assign w_ar_err = (axi_req_i.ar.size > 3'(MaxSize)) | (axi_req_i.ar.burst == 2'b11) |
                     w_wrap_bad;

   assign w_bytes = AxiAddrWidth'(1) << r_size;
   assign w_align = r_addr & ~(w_bytes - AxiAddrWidth'(1));
   assign w_incr  = w_align + w_bytes;
   assign w_wmask = ((AxiAddrWidth'(r_len) + AxiAddrWidth'(1)) << r_size) - AxiAddrWidth'(1);

   always_comb begin
      w_next_addr = w_incr;
      if (r_burst == BurstFixed) begin
         w_next_addr = r_addr;
      end else if (r_burst == BurstWrap) begin
         w_next_addr = (w_align & ~w_wmask) | (w_incr & w_wmask);
      end
   end

   // Error beats consume credit like memory grants but bypass the memory.
   assign w_issue    = (r_state == StBurst) & (r_outst < Credits);
   assign mem_req_o  = w_issue & ~r_err;
   assign mem_addr_o = w_align;
   assign w_gnt      = mem_req_o & mem_gnt_i;
   assign w_err_beat = w_issue & r_err;
   assign w_beat     = w_gnt | w_err_beat;
   assign w_pop      = ~w_empty & axi_req_i.r_ready;

   assign w_push      = (mem_rvalid_i & r_pend_vld) | w_err_beat;
   assign w_push_data = w_err_beat ?
                        {AxiDataWidth'(0), r_id, (r_cnt == 8'd0), RespSlvErr} :
                        {mem_rdata_i, r_id, r_pend_last, RespOkay};

   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         StIdle:  if (w_ar_hs) w_state_d = StBurst;
         StBurst: if (w_beat && (r_cnt == 8'd0)) w_state_d = StIdle;
         default: w_state_d = StIdle;
      endcase
   end

   always_comb begin
      w_outst_d = r_outst;
      if (w_beat && !w_pop) begin
         w_outst_d = r_outst + CntW'(1);
      end else if (!w_beat && w_pop) begin
         w_outst_d = r_outst - CntW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state     <= StIdle;
         r_id        <= '0;
         r_addr      <= '0;
         r_len       <= '0;
         r_cnt       <= '0;
         r_size      <= '0;
         r_burst     <= '0;
         r_err       <= 1'b0;
         r_pend_vld  <= 1'b0;
         r_pend_last <= 1'b0;
         r_outst     <= '0;
      end else begin
         r_state     <= w_state_d;
         r_outst     <= w_outst_d;
         r_pend_vld  <= w_gnt;
         r_pend_last <= w_gnt & (r_cnt == 8'd0);
         if (w_ar_hs) begin
            r_id    <= axi_req_i.ar.id;
            r_addr  <= axi_req_i.ar.addr;
            r_len   <= axi_req_i.ar.len;
            r_cnt   <= axi_req_i.ar.len;
            r_size  <= axi_req_i.ar.size;
            r_burst <= axi_req_i.ar.burst;
            r_err   <= w_ar_err;
         end else if (w_beat) begin
            r_addr <= w_next_addr;
            r_cnt  <= r_cnt - 8'd1;
         end
      end
   end

   axi_rd_responder_fifo #(
      .Width (EntW),
      .Depth (FifoDepth)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .i_push  (w_push),
      .i_data  (w_push_data),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   always_comb begin
      axi_resp_o          = '0;
      axi_resp_o.ar_ready = (r_state == StIdle);
      axi_resp_o.r_valid  = ~w_empty;
      axi_resp_o.r.data   = w_head[EntW-1 -: AxiDataWidth];
      axi_resp_o.r.id     = w_head[AxiIdWidth+2 -: AxiIdWidth];
      axi_resp_o.r.last   = w_head[2] & ~w_empty;
      axi_resp_o.r.resp   = w_head[1:0];
   end

endmodule
